// File: rtl/store_bin.sv
// Write-back of one finished bin: scatters the engine's var states to their global
// addresses (looked up through the vars-bin RAM), then writes the lvl states from base_lvl upward.
module store_bin #(
  parameter int NUM_VARS_A_BIN         = 8,
  parameter int NUM_LVLS_A_BIN         = 8,
  parameter int WIDTH_BIN_ID           = 10,
  parameter int WIDTH_VARS             = 12,
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_VAR_STATES       = 30,
  parameter int WIDTH_LVL_STATES       = 30,
  parameter int ADDR_WIDTH_VARS        = 9,
  parameter int ADDR_WIDTH_VARS_STATES = 9,
  parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_store,
  input  logic [WIDTH_BIN_ID-1:0]                      request_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
  input  logic [3:0]                                   num_lvls_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   var_state_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
  output logic                                         apply_store_o,
  output logic                                         done_store,
  input  logic [WIDTH_VARS-1:0]                        ram_data_v_i,
  output logic [ADDR_WIDTH_VARS-1:0]                   ram_addr_v_o,
  output logic                                         ram_we_v_state_o,
  output logic [ADDR_WIDTH_VARS_STATES-1:0]            ram_addr_v_state_o,
  output logic [WIDTH_VAR_STATES-1:0]                  ram_data_v_state_o,
  output logic                                         ram_we_l_state_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0]            ram_addr_l_state_o,
  output logic [WIDTH_LVL_STATES-1:0]                  ram_data_l_state_o
);

  localparam int N   = NUM_VARS_A_BIN;
  localparam int L   = NUM_LVLS_A_BIN;
  localparam int CW  = $clog2(N + L + 3) + 1;
  localparam int VIW = (N > 1) ? $clog2(N) : 1;
  localparam int LIW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [4:0]    L_CLAMP = 5'(L);

  typedef enum logic [1:0] {IDLE, VAR, LVL, DONE} state_t;

  state_t                                     state_reg;
  logic [CW-1:0]                              cnt_reg;
  logic [ADDR_WIDTH_VARS-1:0]                 base_v_reg;
  logic [WIDTH_LVL-1:0]                       lvl_ptr_reg;
  logic [4:0]                                 nlvl_reg;
  logic [WIDTH_VAR_STATES*N-1:0]              var_snap_reg;
  logic [WIDTH_LVL_STATES*L-1:0]              lvl_snap_reg;

  logic [WIDTH_VAR_STATES-1:0]                var_slot [N];
  logic [WIDTH_LVL_STATES-1:0]                lvl_slot [L];
  logic [VIW-1:0]                             var_idx;
  logic [LIW-1:0]                             lvl_idx_next;
  logic [ADDR_WIDTH_VARS-1:0]                 base_v_next;
  logic [4:0]                                 nlvl_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_var_slot
      assign var_slot[gi] = var_snap_reg[gi*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
    end
    for (gi = 0; gi < L; gi++) begin : g_lvl_slot
      assign lvl_slot[gi] = lvl_snap_reg[gi*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
    end
  endgenerate

  // Read data in VAR count c belongs to the address issued one cycle earlier, i.e. slot c-1.
  assign var_idx      = VIW'(cnt_reg - 1'b1);
  assign lvl_idx_next = LIW'(cnt_reg + 1'b1);
  assign base_v_next  = ADDR_WIDTH_VARS'(32'(request_bin_num_i) * 32'(N));
  assign nlvl_clamped = ({1'b0, num_lvls_i} > L_CLAMP) ? L_CLAMP : {1'b0, num_lvls_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      base_v_reg         <= '0;
      lvl_ptr_reg        <= '0;
      nlvl_reg           <= '0;
      var_snap_reg       <= '0;
      lvl_snap_reg       <= '0;
      apply_store_o      <= 1'b0;
      done_store         <= 1'b0;
      ram_addr_v_o       <= '0;
      ram_we_v_state_o   <= 1'b0;
      ram_addr_v_state_o <= '0;
      ram_data_v_state_o <= '0;
      ram_we_l_state_o   <= 1'b0;
      ram_addr_l_state_o <= '0;
      ram_data_l_state_o <= '0;
    end else begin
      done_store         <= 1'b0;
      ram_addr_v_o       <= '0;
      ram_we_v_state_o   <= 1'b0;
      ram_addr_v_state_o <= '0;
      ram_data_v_state_o <= '0;
      ram_we_l_state_o   <= 1'b0;
      ram_addr_l_state_o <= '0;
      ram_data_l_state_o <= '0;
      case (state_reg)
        IDLE: begin
          if (start_store) begin
            state_reg     <= VAR;
            cnt_reg       <= '0;
            apply_store_o <= 1'b1;
            base_v_reg    <= base_v_next;
            ram_addr_v_o  <= base_v_next;
            lvl_ptr_reg   <= base_lvl_i;
            nlvl_reg      <= nlvl_clamped;
            var_snap_reg  <= var_state_i;
            lvl_snap_reg  <= lvl_states_i;
          end
        end
        VAR: begin
          if ((cnt_reg + 1'b1) < N_CNT) begin
            ram_addr_v_o <= base_v_reg + ADDR_WIDTH_VARS'(cnt_reg + 1'b1);
          end
          // Id 0 marks an unused slot: leave the write port idle.
          if ((cnt_reg != '0) && (cnt_reg <= N_CNT) && (ram_data_v_i != '0)) begin
            ram_we_v_state_o   <= 1'b1;
            ram_addr_v_state_o <= ram_data_v_i[ADDR_WIDTH_VARS_STATES-1:0];
            ram_data_v_state_o <= var_slot[var_idx];
          end
          if (cnt_reg == N_CNT + 1'b1) begin
            cnt_reg <= '0;
            if (nlvl_reg == '0) begin
              state_reg     <= DONE;
              done_store    <= 1'b1;
              apply_store_o <= 1'b0;
            end else begin
              state_reg          <= LVL;
              ram_we_l_state_o   <= 1'b1;
              ram_addr_l_state_o <= lvl_ptr_reg[ADDR_WIDTH_LVLS_STATES-1:0];
              ram_data_l_state_o <= lvl_slot[0];
              lvl_ptr_reg        <= lvl_ptr_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LVL: begin
          if ((cnt_reg + 1'b1) < CW'(nlvl_reg)) begin
            cnt_reg            <= cnt_reg + 1'b1;
            ram_we_l_state_o   <= 1'b1;
            ram_addr_l_state_o <= lvl_ptr_reg[ADDR_WIDTH_LVLS_STATES-1:0];
            ram_data_l_state_o <= lvl_slot[lvl_idx_next];
            lvl_ptr_reg        <= lvl_ptr_reg + 1'b1;
          end else begin
            state_reg     <= DONE;
            done_store    <= 1'b1;
            apply_store_o <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_bin.sv
// Directed bench for store_bin: hand-set vars-bin ids and state patterns,
// cycle-by-cycle expectations relative to the start_store sampling edge.
module tb_store_bin;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_store;
  logic [9:0]   request_bin_num_i;
  logic [15:0]  base_lvl_i;
  logic [3:0]   num_lvls_i;
  logic [239:0] var_state_i;
  logic [239:0] lvl_states_i;
  logic         apply_store_o;
  logic         done_store;
  logic [11:0]  ram_data_v_i;
  logic [8:0]   ram_addr_v_o;
  logic         ram_we_v_state_o;
  logic [8:0]   ram_addr_v_state_o;
  logic [29:0]  ram_data_v_state_o;
  logic         ram_we_l_state_o;
  logic [8:0]   ram_addr_l_state_o;
  logic [29:0]  ram_data_l_state_o;

  logic [11:0]  vars_mem [512];
  logic [11:0]  ids [8];
  logic [29:0]  snap_var [8];
  logic [29:0]  snap_lvl [8];
  int           n_pass = 0;
  int           n_fail = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  // Vars-bin RAM with one cycle of read latency.
  always @(posedge clk) ram_data_v_i <= vars_mem[ram_addr_v_o];

  store_bin dut (
    .clk                (clk),
    .rst                (rst),
    .start_store        (start_store),
    .request_bin_num_i  (request_bin_num_i),
    .base_lvl_i         (base_lvl_i),
    .num_lvls_i         (num_lvls_i),
    .var_state_i        (var_state_i),
    .lvl_states_i       (lvl_states_i),
    .apply_store_o      (apply_store_o),
    .done_store         (done_store),
    .ram_data_v_i       (ram_data_v_i),
    .ram_addr_v_o       (ram_addr_v_o),
    .ram_we_v_state_o   (ram_we_v_state_o),
    .ram_addr_v_state_o (ram_addr_v_state_o),
    .ram_data_v_state_o (ram_data_v_state_o),
    .ram_we_l_state_o   (ram_we_l_state_o),
    .ram_addr_l_state_o (ram_addr_l_state_o),
    .ram_data_l_state_o (ram_data_l_state_o)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, c, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int c);
    chk({tag, ".apply"}, c, 32'(apply_store_o), 0);
    chk({tag, ".done"}, c, 32'(done_store), 0);
    chk({tag, ".addr_v"}, c, 32'(ram_addr_v_o), 0);
    chk({tag, ".vwe"}, c, 32'(ram_we_v_state_o), 0);
    chk({tag, ".vaddr"}, c, 32'(ram_addr_v_state_o), 0);
    chk({tag, ".vdata"}, c, 32'(ram_data_v_state_o), 0);
    chk({tag, ".lwe"}, c, 32'(ram_we_l_state_o), 0);
    chk({tag, ".laddr"}, c, 32'(ram_addr_l_state_o), 0);
    chk({tag, ".ldata"}, c, 32'(ram_data_l_state_o), 0);
  endtask

  task automatic setup(input int bin, input int blvl, input int nin);
    for (int k = 0; k < 8; k++) begin
      vars_mem[(bin * 8 + k) % 512] = ids[k];
      snap_var[k] = 30'((bin << 12) | (k << 4) | 5);
      snap_lvl[k] = 30'(32'h0200_0000 | (blvl << 8) | k);
      var_state_i[k*30 +: 30]  = snap_var[k];
      lvl_states_i[k*30 +: 30] = snap_lvl[k];
    end
    request_bin_num_i = 10'(bin);
    base_lvl_i        = 16'(blvl);
    num_lvls_i        = 4'(nin);
  endtask

  task automatic do_store(input string tag, input int bin, input int blvl, input int nin,
                          input int neff, input bit disturb);
    int k;
    int j;
    setup(bin, blvl, nin);
    @(negedge clk) start_store = 1'b1;
    @(negedge clk) start_store = 1'b0;
    for (int c = 1; c <= 13 + neff; c++) begin
      k = c - 3;
      j = c - 11;
      chk({tag, ".addr_v"}, c, 32'(ram_addr_v_o), (c <= 8) ? 32'((bin * 8 + c - 1) % 512) : 0);
      if (k >= 0 && k < 8 && ids[k] != 0) begin
        chk({tag, ".vwe"}, c, 32'(ram_we_v_state_o), 1);
        chk({tag, ".vaddr"}, c, 32'(ram_addr_v_state_o), 32'(ids[k][8:0]));
        chk({tag, ".vdata"}, c, 32'(ram_data_v_state_o), 32'(snap_var[k]));
      end else begin
        chk({tag, ".vwe"}, c, 32'(ram_we_v_state_o), 0);
        chk({tag, ".vaddr"}, c, 32'(ram_addr_v_state_o), 0);
        chk({tag, ".vdata"}, c, 32'(ram_data_v_state_o), 0);
      end
      if (j >= 0 && j < neff) begin
        chk({tag, ".lwe"}, c, 32'(ram_we_l_state_o), 1);
        chk({tag, ".laddr"}, c, 32'(ram_addr_l_state_o), 32'((blvl + j) % 512));
        chk({tag, ".ldata"}, c, 32'(ram_data_l_state_o), 32'(snap_lvl[j]));
      end else begin
        chk({tag, ".lwe"}, c, 32'(ram_we_l_state_o), 0);
        chk({tag, ".laddr"}, c, 32'(ram_addr_l_state_o), 0);
        chk({tag, ".ldata"}, c, 32'(ram_data_l_state_o), 0);
      end
      chk({tag, ".done"}, c, 32'(done_store), (c == 11 + neff) ? 1 : 0);
      chk({tag, ".apply"}, c, 32'(apply_store_o), (c <= 10 + neff) ? 1 : 0);
      if (disturb) begin
        for (int s = 0; s < 8; s++) begin
          var_state_i[s*30 +: 30]  = 30'($urandom);
          lvl_states_i[s*30 +: 30] = 30'($urandom);
        end
        request_bin_num_i = 10'($urandom);
        base_lvl_i        = 16'($urandom);
        num_lvls_i        = 4'($urandom);
        start_store       = (c == 4);
      end
      @(negedge clk);
    end
    start_store = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_store = 1'b0;
    request_bin_num_i = '0;
    base_lvl_i = '0;
    num_lvls_i = '0;
    var_state_i = '0;
    lvl_states_i = '0;
    for (int i = 0; i < 512; i++) vars_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset", 0);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset", 0);

    for (int k = 0; k < 8; k++) ids[k] = 12'(k + 1);
    do_store("full", 3, 5, 3, 3, 1'b0);

    ids = '{12'd4, 12'd0, 12'd7, 12'd0, 12'd0, 12'd0, 12'd0, 12'd9};
    do_store("empty", 3, 40, 2, 2, 1'b0);

    for (int k = 0; k < 8; k++) ids[k] = 12'(100 + k);
    do_store("n0", 5, 77, 0, 0, 1'b0);

    for (int k = 0; k < 8; k++) ids[k] = 12'(12'h800 | (300 + k));
    do_store("clamp", 70, 510, 12, 8, 1'b0);

    for (int k = 0; k < 8; k++) ids[k] = 12'(11 + k);
    do_store("stable", 3, 5, 3, 3, 1'b1);

    // Abort a store with reset in cycle 6, then confirm a clean restart.
    for (int k = 0; k < 8; k++) ids[k] = 12'(50 + k);
    setup(2, 20, 4);
    @(negedge clk) start_store = 1'b1;
    @(negedge clk) start_store = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("abort", 7);
    rst = 1'b0;
    for (int c = 8; c < 22; c++) begin
      @(negedge clk);
      chk("abort.vwe", c, 32'(ram_we_v_state_o), 0);
      chk("abort.lwe", c, 32'(ram_we_l_state_o), 0);
      chk("abort.done", c, 32'(done_store), 0);
      chk("abort.apply", c, 32'(apply_store_o), 0);
    end
    do_store("restart", 2, 20, 4, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_bin.md
# store_bin

Write-back stage for the bin manager. When the SAT engine finishes a bin, this block snapshots the engine's per-bin var states and lvl states. It scatters each var state to its global address, found through a vars-bin id lookup, and writes the lvl states back to the global lvl-state RAM starting at the bin's base level. It runs immediately before the next bin is loaded and shares the same vars, var-state and lvl-state BRAMs with the loader.

## Interface
- NUM_VARS_A_BIN, 8, var slots per bin (N)
- NUM_LVLS_A_BIN, 8, lvl slots per bin
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_VARS, 12, global var id width
- WIDTH_LVL, 16, level width
- WIDTH_VAR_STATES, 30, one var-state word
- WIDTH_LVL_STATES, 30, one lvl-state word
- ADDR_WIDTH_VARS, 9, vars-bin RAM address width
- ADDR_WIDTH_VARS_STATES, 9, var-state RAM address width
- ADDR_WIDTH_LVLS_STATES, 9, lvl-state RAM address width
- Reset: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_store  in  1  one-cycle start pulse, sampled only in IDLE
- request_bin_num_i  in  WIDTH_BIN_ID  bin being stored
- base_lvl_i  in  WIDTH_LVL  first global level of the bin
- num_lvls_i  in  4  valid lvl slots (n); clamped to NUM_LVLS_A_BIN
- var_state_i  in  WIDTH_VAR_STATES*N  engine var states; slot k = [k*W +: W]
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  engine lvl states, same slot packing
- apply_store_o  out  1  BRAM mux ownership
- done_store  out  1  one-cycle completion pulse
- ram_data_v_i  in  WIDTH_VARS  vars-bin read data, 1-cycle latency
- ram_addr_v_o  out  ADDR_WIDTH_VARS  vars-bin read address
- ram_we_v_state_o  out  1  var-state write enable
- ram_addr_v_state_o  out  ADDR_WIDTH_VARS_STATES  var-state write address
- ram_data_v_state_o  out  WIDTH_VAR_STATES  var-state write data
- ram_we_l_state_o  out  1  lvl-state write enable
- ram_addr_l_state_o  out  ADDR_WIDTH_LVLS_STATES  lvl-state write address
- ram_data_l_state_o  out  WIDTH_LVL_STATES  lvl-state write data

## Operation
- States and transitions:
  - IDLE → VAR on start_store.
  - VAR → LVL after N+2 cycles.
  - LVL → DONE after n cycles; with n=0, VAR → DONE directly.
  - DONE → IDLE unconditionally.
- On accept, the block latches request_bin_num_i, base_lvl_i, clamped num_lvls_i, var_state_i and lvl_states_i. Later input changes have no effect.
- Var base address = request_bin_num_i*N, truncated to ADDR_WIDTH_VARS.
- VAR phase:
  - Issue ram_addr_v_o = base+k for k=0..N-1.
  - The returned id v determines the write for slot k: addr = v[ADDR_WIDTH_VARS_STATES-1:0], data = slot k, we = (v!=0).
  - Id 0 marks an empty slot: no write.
- LVL phase: for j=0..n-1, write addr = (base_lvl+j) truncated to ADDR_WIDTH_LVLS_STATES, data = lvl slot j, we=1.
- start_store while not in IDLE is ignored and not queued.
- Reset value of every output is 0. Between writes, we=0 and the write address and data are 0. ram_addr_v_o is 0 outside VAR.
- Reset mid-operation:
  - State returns to IDLE.
  - No write strobe in the cycle after reset deasserts.
  - No done_store pulse for the aborted store.

## Timing
- Cycle 1 is the first cycle after the edge that samples start_store.
- ram_addr_v_o = base+k in cycle k+1.
- Var slot k write is visible in cycle k+3, so var writes occupy cycles 3..N+2.
- Lvl slot j write is visible in cycle N+3+j.
- done_store is high for exactly one cycle, in cycle N+3+n.
- apply_store_o is high in cycles 1..N+2+n and low in the done_store cycle.
- Var and lvl write ports are never both enabled in the same cycle.
- A new start_store is accepted earliest in the cycle after done_store.

## Test plan
- Full store, N=8:
  - Stimulus: bin 3, ids 1..8 in vars RAM at addresses 24..31, n=3, base_lvl=5.
  - Response: var writes to addresses 1..8 in cycles 3..10; lvl writes to addresses 5,6,7 in cycles 11..13; done_store in cycle 14.
- Empty slots: vars at addresses 24..31 hold ids 4,0,7,0,0,0,0,9 → exactly three var writes (addresses 4,7,9 in cycles 3,5,10), we low on all other slots.
- n=0 → no lvl writes; done_store in cycle 11; apply_store_o is high in cycles 1..10.
- Clamp and truncation:
  - Stimulus: num_lvls_i=12, base_lvl=510, ADDR_WIDTH_LVLS_STATES=9.
  - Response: 8 lvl writes to addresses 510,511,0,1,…,5.
- Input stability:
  - Stimulus: change var_state_i and lvl_states_i every cycle after start; pulse start_store again in cycle 4.
  - Response: written data equals the start-cycle snapshot; the second start is ignored; only one done_store.
- Reset mid-operation: rst in cycle 6 → all outputs 0 in the next cycle, no further writes, no done_store; a new start_store after reset completes normally.
